// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: valid/ready issue front-end and write-back for the 4-bit bitAlu.
// It holds a NREG x DW register file. A load writes it in the accept cycle.
// An ALU op registers its operands at accept and writes the result back one cycle later.
// Optional build macro: ALU_ISSUE_FLAGS_EN adds the res_zero and res_cnt outputs.
module alu_issue_ctrl #(
    parameter int unsigned DW   = 4,
    parameter int unsigned NREG = 4,
    localparam int unsigned AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_ld,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_ra,
    input  logic [AW-1:0] in_rb,
    input  logic [DW-1:0] in_imm,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_sel,
    input  logic [DW-1:0] alu_res,
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic [AW-1:0] res_rd,
`ifdef ALU_ISSUE_FLAGS_EN
    output logic          res_zero,
    output logic [7:0]    res_cnt,
`endif
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    typedef enum logic {StIdle, StExec} state_e;

    state_e        r_state;
    state_e        w_state_d;
    logic          w_accept;
    logic          w_wr;
    logic [DW-1:0] w_wdata;
    logic [AW-1:0] w_wrd;

    logic [DW-1:0] r_rf [NREG];
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic [2:0]    r_alu_sel;
    logic [AW-1:0] r_rd;
    logic          r_res_valid;
    logic [DW-1:0] r_res_data;
    logic [AW-1:0] r_res_rd;

    // State register; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state, ready decode and a single write-back port shared by loads and EXEC.
    always_comb begin
        w_state_d = r_state;
        in_ready  = 1'b0;
        w_accept  = 1'b0;
        w_wr      = 1'b0;
        w_wdata   = in_imm;
        w_wrd     = in_rd;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) begin
                    if (in_ld) begin
                        w_wr = 1'b1;
                    end else begin
                        w_state_d = StExec;
                    end
                end
            end
            StExec: begin
                w_wr      = 1'b1;
                w_wdata   = alu_res;
                w_wrd     = r_rd;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Datapath: register file, ALU operand registers and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= 3'b000;
            r_rd        <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_rd    <= '0;
        end else begin
            r_res_valid <= w_wr;
            if (w_wr) begin
                r_rf[w_wrd] <= w_wdata;
                r_res_data  <= w_wdata;
                r_res_rd    <= w_wrd;
            end
            // Sources read pre-edge contents, so ra == rd on the same op is safe.
            if (w_accept && !in_ld) begin
                r_alu_a   <= r_rf[in_ra];
                r_alu_b   <= r_rf[in_rb];
                r_alu_sel <= in_op;
                r_rd      <= in_rd;
            end
        end
    end

`ifdef ALU_ISSUE_FLAGS_EN
    logic       r_res_zero;
    logic [7:0] r_res_cnt;

    // Zero flag tracks res_data; counter wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_zero <= 1'b0;
            r_res_cnt  <= 8'd0;
        end else if (w_wr) begin
            r_res_zero <= (w_wdata == '0);
            r_res_cnt  <= r_res_cnt + 8'd1;
        end
    end

    assign res_zero = r_res_zero;
    assign res_cnt  = r_res_cnt;
`endif

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_rd    = r_res_rd;
    assign dbg_data  = r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl.
// A behavioural stand-in for bitAlu closes the loop from alu_a/alu_b/alu_sel to alu_res.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_ld;
    logic [2:0] in_op;
    logic [1:0] in_rd, in_ra, in_rb;
    logic [3:0] in_imm;
    logic [3:0] alu_a, alu_b, alu_res;
    logic [2:0] alu_sel;
    logic       res_valid;
    logic [3:0] res_data;
    logic [1:0] res_rd;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;
`ifdef ALU_ISSUE_FLAGS_EN
    logic       res_zero;
    logic [7:0] res_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clk = ~clk;

    // ALU stand-in: 000 add, 001 A<<1, 010 and, 011 xor, 100 A-B, 101 or, 110 ~A+B, 111 A.
    always_comb begin
        alu_res = alu_a;
        case (alu_sel)
            3'b000: alu_res = alu_a + alu_b;
            3'b001: alu_res = {alu_a[2:0], 1'b0};
            3'b010: alu_res = alu_a & alu_b;
            3'b011: alu_res = alu_a ^ alu_b;
            3'b100: alu_res = alu_a - alu_b;
            3'b101: alu_res = alu_a | alu_b;
            3'b110: alu_res = ~alu_a + alu_b;
            default: alu_res = alu_a;
        endcase
    end

    alu_issue_ctrl #(.DW(4), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ld(in_ld), .in_op(in_op),
        .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
        .res_valid(res_valid), .res_data(res_data), .res_rd(res_rd),
`ifdef ALU_ISSUE_FLAGS_EN
        .res_zero(res_zero), .res_cnt(res_cnt),
`endif
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg(input string tag, input logic [1:0] addr, input logic [3:0] exp);
        dbg_addr = addr;
        #1;
        check(tag, {28'd0, dbg_data}, {28'd0, exp});
    endtask

    task automatic set_ld(input logic [1:0] rd, input logic [3:0] imm);
        in_valid = 1'b1; in_ld = 1'b1; in_rd = rd; in_imm = imm;
    endtask

    task automatic set_op(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                          input logic [1:0] rd);
        in_valid = 1'b1; in_ld = 1'b0; in_op = op; in_ra = ra; in_rb = rb; in_rd = rd;
    endtask

    // Full ALU op: accept, check operands in EXEC, then check write-back.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [1:0] ra,
                         input logic [1:0] rb, input logic [1:0] rd,
                         input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] eres);
        set_op(op, ra, rb, rd);
        tick();
        in_valid = 1'b0;
        check({tag, "_a"}, {28'd0, alu_a}, {28'd0, ea});
        check({tag, "_b"}, {28'd0, alu_b}, {28'd0, eb});
        check({tag, "_sel"}, {29'd0, alu_sel}, {29'd0, op});
        check({tag, "_rdy_exec"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_vld_exec"}, {31'd0, res_valid}, 32'd0);
        tick();
        check({tag, "_vld"}, {31'd0, res_valid}, 32'd1);
        check({tag, "_data"}, {28'd0, res_data}, {28'd0, eres});
        check({tag, "_rd"}, {30'd0, res_rd}, {30'd0, rd});
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        dbg({tag, "_rf"}, rd, eres);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ld = 1'b0; in_op = 3'b000;
        in_rd = 2'd0; in_ra = 2'd0; in_rb = 2'd0; in_imm = 4'd0; dbg_addr = 2'd0;
        #12;
        for (int i = 0; i < 4; i++) dbg("rst_rf", 2'(i), 4'h0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_sel", {29'd0, alu_sel}, 32'd0);
        check("rst_vld", {31'd0, res_valid}, 32'd0);
        check("rst_data", {28'd0, res_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back loads r0=5, r1=3.
        set_ld(2'd0, 4'h5);
        tick();
        check("ld0_vld", {31'd0, res_valid}, 32'd1);
        check("ld0_data", {28'd0, res_data}, 32'h5);
        set_ld(2'd1, 4'h3);
        tick();
        in_valid = 1'b0;
        check("ld1_vld", {31'd0, res_valid}, 32'd1);
        check("ld1_data", {28'd0, res_data}, 32'h3);
        check("ld1_rd", {30'd0, res_rd}, 32'd1);
        check("ld_keep_sel", {29'd0, alu_sel}, 32'd0);
        tick();
        check("ld_pulse_end", {31'd0, res_valid}, 32'd0);
        check("ld_hold_data", {28'd0, res_data}, 32'h3);

        // Shift left: 5<<1 = A into r2.
        do_op("shl", 3'b001, 2'd0, 2'd0, 2'd2, 4'h5, 4'h5, 4'hA);
        tick();
        check("op_pulse_end", {31'd0, res_valid}, 32'd0);
        check("op_hold_a", {28'd0, alu_a}, 32'h5);

        // r0=C, r1=A; xor -> 6 into r3; then ~A+B = 5+C -> 1 into r1.
        set_ld(2'd0, 4'hC);
        tick();
        set_ld(2'd1, 4'hA);
        tick();
        in_valid = 1'b0;
        check("ld_keep_a", {28'd0, alu_a}, 32'h5);
        do_op("xor", 3'b011, 2'd0, 2'd1, 2'd3, 4'hC, 4'hA, 4'h6);
        do_op("nota", 3'b110, 2'd1, 2'd0, 2'd1, 4'hA, 4'hC, 4'h1);

        // in_valid held high: accepts at steps 0,2,4; C+C=8 into r2 each time.
        set_op(3'b000, 2'd0, 2'd0, 2'd2);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            check("hold_ready", {31'd0, in_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            tick();
            if (res_valid) pulses++;
        end
        in_valid = 1'b0;
        tick();
        if (res_valid) pulses++;
        check("hold_pulses", pulses, 32'd3);
        dbg("hold_rf", 2'd2, 4'h8);

        // Reset during EXEC of op 101 on r2 (holding 7).
        set_ld(2'd2, 4'h7);
        tick();
        in_valid = 1'b0;
        dbg("pre_abort_rf", 2'd2, 4'h7);
        set_op(3'b101, 2'd0, 2'd1, 2'd2);
        tick();
        in_valid = 1'b0;
        check("abort_in_exec", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        check("abort_vld", {31'd0, res_valid}, 32'd0);
        dbg("abort_rf", 2'd2, 4'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (res_valid) pulses++;
        end
        check("abort_no_pulse", pulses, 32'd0);
        check("abort_idle", {31'd0, in_ready}, 32'd1);
        dbg("abort_rf_after", 2'd2, 4'h0);

`ifdef ALU_ISSUE_FLAGS_EN
        check("cnt_rst", {24'd0, res_cnt}, 32'd0);
        set_ld(2'd0, 4'hF);
        tick();
        set_ld(2'd1, 4'hF);
        tick();
        in_valid = 1'b0;
        check("zero_ld", {31'd0, res_zero}, 32'd0);
        do_op("sub", 3'b100, 2'd0, 2'd1, 2'd3, 4'hF, 4'hF, 4'h0);
        check("zero_flag", {31'd0, res_zero}, 32'd1);
        check("cnt_3", {24'd0, res_cnt}, 32'd3);
        for (int i = 0; i < 253; i++) begin
            set_ld(2'd0, 4'h1);
            tick();
        end
        in_valid = 1'b0;
        check("cnt_wrap", {24'd0, res_cnt}, 32'd0);
        check("zero_clear", {31'd0, res_zero}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
